// File: rtl/ddr4_refresh_sequencer.sv
// DDR4 refresh sequencer: tracks tREFI, counts owed refreshes and sweeps one REF per
// bank (ba fastest, bg outer) once granted the command bus, then waits tRFC and retires.
module ddr4_refresh_sequencer #(
    parameter int unsigned RANKS        = 1,
    parameter int unsigned BGWIDTH      = 2,
    parameter int unsigned BAWIDTH      = 2,
    parameter int unsigned ADDRWIDTH    = 17,
    parameter int unsigned TREFI        = 7800,
    parameter int unsigned REF_GAP      = 1,
    parameter int unsigned TRFC         = 36,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic                 ck_t,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 bus_gnt,
    output logic                 ref_req,
    output logic                 ref_busy,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [3:0]           pending,
    output logic                 overflow,
    output logic                 ref_done
);

    localparam int unsigned BANKW  = BGWIDTH + BAWIDTH;
    localparam int unsigned BCW    = BANKW + 1;
    localparam int unsigned NBANKS = 1 << BANKW;
    localparam int unsigned ICW    = $clog2(TREFI);
    localparam int unsigned GCW    = $clog2(REF_GAP + 1);
    localparam int unsigned RCW    = $clog2(TRFC + 1);

    localparam logic [ICW-1:0]       ILAST = ICW'(TREFI - 1);
    localparam logic [GCW-1:0]       GLAST = GCW'((REF_GAP > 1) ? (REF_GAP - 2) : 0);
    localparam logic [RCW-1:0]       RLAST = RCW'(TRFC - 1);
    localparam logic [BCW-1:0]       BLAST = BCW'(NBANKS - 1);
    localparam logic [BCW-1:0]       BEND  = BCW'(NBANKS);
    localparam logic [3:0]           PMAX  = 4'(MAX_POSTPONE);
    localparam logic [ADDRWIDTH-1:0] A_REF = ADDRWIDTH'(17'h04001);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_GAP,
        S_RECOVER
    } state_e;

    state_e               state_q, state_d;
    logic [ICW-1:0]       icnt_q, icnt_d;
    logic [BCW-1:0]       bank_q, bank_d;
    logic [GCW-1:0]       gcnt_q, gcnt_d;
    logic [RCW-1:0]       rcnt_q, rcnt_d;
    logic [3:0]           pend_q, pend_d;
    logic                 ovf_q, ovf_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RANKS-1:0]     cs_n_q, cs_n_d;
    logic [ADDRWIDTH-1:0] a_q, a_d;
    logic [BGWIDTH-1:0]   bg_q, bg_d;
    logic [BAWIDTH-1:0]   ba_q, ba_d;
    logic                 tick, retire, issue_d;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        gcnt_d  = gcnt_q;
        rcnt_d  = rcnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        retire  = 1'b0;
        tick    = (icnt_q == ILAST);
        icnt_d  = tick ? '0 : icnt_q + ICW'(1);

        case (state_q)
            S_IDLE: begin
                if (en && (pend_q != 4'd0)) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus_gnt) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // bank counter runs one past the last bank so GAP knows the sweep is over
                bank_d = bank_q + BCW'(1);
                gcnt_d = '0;
                rcnt_d = '0;
                if (REF_GAP > 1)          state_d = S_GAP;
                else if (bank_q == BLAST) state_d = S_RECOVER;
                else                      state_d = S_ISSUE;
            end
            S_GAP: begin
                rcnt_d = '0;
                if (gcnt_q == GLAST) state_d = (bank_q == BEND) ? S_RECOVER : S_ISSUE;
                else                 gcnt_d = gcnt_q + GCW'(1);
            end
            S_RECOVER: begin
                if (rcnt_q == RLAST) begin
                    retire  = 1'b1;
                    bank_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a tick and a retire in the same cycle cancel out
        if (tick && !retire) begin
            if (pend_q == PMAX) ovf_d  = 1'b1;
            else                pend_d = pend_q + 4'd1;
        end else if (retire && !tick && (pend_q != 4'd0)) begin
            pend_d = pend_q - 4'd1;
        end

        issue_d = (state_d == S_ISSUE);
        req_d   = (state_d == S_REQ);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_GAP) || (state_d == S_RECOVER);
        done_d  = (state_d == S_RECOVER) && (rcnt_d == RLAST);
        cs_n_d  = issue_d ? '0 : '1;
        a_d     = issue_d ? A_REF : '0;
        bg_d    = issue_d ? bank_d[BANKW-1:BAWIDTH] : '0;
        ba_d    = issue_d ? bank_d[BAWIDTH-1:0] : '0;
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            icnt_q  <= '0;
            bank_q  <= '0;
            gcnt_q  <= '0;
            rcnt_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= '1;
            a_q     <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            bank_q  <= bank_d;
            gcnt_q  <= gcnt_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            a_q     <= a_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
        end
    end

    assign ref_req  = req_q;
    assign ref_busy = busy_q;
    assign ref_done = done_q;
    assign cs_n     = cs_n_q;
    assign act_n    = 1'b1;
    assign A        = a_q;
    assign bg       = bg_q;
    assign ba       = ba_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ddr4_refresh_sequencer.sv
// Bench for ddr4_refresh_sequencer: instance A (back-to-back REFs) runs a phase table,
// instance B (REF_GAP=3, TREFI aligned so every retire meets a tick) free-runs.
module tb_ddr4_refresh_sequencer;

    localparam int NB     = 16;
    localparam int TRFC   = 36;
    localparam int GAP_A  = 1;
    localparam int GAP_B  = 3;
    localparam int NVEC   = 7;

    logic ck_t = 1'b0;
    always #5 ck_t = ~ck_t;

    logic        rst_a = 1'b0, en_a = 1'b0, gnt_a = 1'b0;
    logic        req_a, busy_a, act_a, ovf_a, done_a;
    logic [0:0]  cs_a;
    logic [16:0] a_a;
    logic [1:0]  bg_a, ba_a;
    logic [3:0]  pend_a;

    logic        rst_b = 1'b0, en_b = 1'b1, gnt_b = 1'b1;
    logic        req_b, busy_b, act_b, ovf_b, done_b;
    logic [0:0]  cs_b;
    logic [16:0] a_b;
    logic [1:0]  bg_b, ba_b;
    logic [3:0]  pend_b;

    ddr4_refresh_sequencer #(.TREFI(80), .REF_GAP(GAP_A), .TRFC(TRFC), .MAX_POSTPONE(8)) dut_a (
        .ck_t(ck_t), .reset_n(rst_a), .en(en_a), .bus_gnt(gnt_a),
        .ref_req(req_a), .ref_busy(busy_a), .cs_n(cs_a), .act_n(act_a), .A(a_a),
        .bg(bg_a), .ba(ba_a), .pending(pend_a), .overflow(ovf_a), .ref_done(done_a));

    ddr4_refresh_sequencer #(.TREFI(86), .REF_GAP(GAP_B), .TRFC(TRFC), .MAX_POSTPONE(8)) dut_b (
        .ck_t(ck_t), .reset_n(rst_b), .en(en_b), .bus_gnt(gnt_b),
        .ref_req(req_b), .ref_busy(busy_b), .cs_n(cs_b), .act_n(act_b), .A(a_b),
        .bg(bg_b), .ba(ba_b), .pending(pend_b), .overflow(ovf_b), .ref_done(done_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard entries: expected bank and sample index of each REF of a sweep
    typedef struct { int bank; int cyc; } ref_t;
    ref_t q_a[$];
    ref_t q_b[$];

    int cyc[2]       = '{0, 0};
    int grant_cyc[2] = '{0, 0};
    int refs[2]      = '{0, 0};
    int sweeps[2]    = '{0, 0};
    bit prev_req[2]  = '{0, 0};
    bit in_sweep[2]  = '{0, 0};
    bit after_done   = 1'b0;
    bit gnt_seen[2];

    always @(posedge ck_t) begin
        gnt_seen[0] <= gnt_a;
        gnt_seen[1] <= gnt_b;
    end

    task automatic mon(input int id, input int gap, input logic rst, input logic req,
                       input logic busy, input logic cs, input logic act, input logic [16:0] a,
                       input logic [1:0] bgv, input logic [1:0] bav, input logic [3:0] pend,
                       input logic ovf, input logic done);
        ref_t e;
        int   qs;
        if (!rst) begin
            if (id == 0) q_a.delete(); else q_b.delete();
            prev_req[id] = 1'b0;
            in_sweep[id] = 1'b0;
            cyc[id]++;
            return;
        end
        // grant taken at the edge just before this sample: push the full expected sweep
        if (prev_req[id] && gnt_seen[id]) begin
            for (int i = 0; i < NB; i++) begin
                e.bank = i;
                e.cyc  = cyc[id] + i * gap;
                if (id == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            grant_cyc[id] = cyc[id] - 1;
            in_sweep[id]  = 1'b1;
        end
        chk($sformatf("dut%0d_busy", id), int'(busy), int'(in_sweep[id]));
        qs = (id == 0) ? q_a.size() : q_b.size();
        if (!cs) begin
            refs[id]++;
            n_tests++;
            if (qs == 0) begin
                n_fail++;
                $display("FAIL dut%0d_unexpected_ref: REF bg=%0d ba=%0d, expected none (t=%0t)",
                         id, bgv, bav, $time);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                chk($sformatf("dut%0d_ref_bank", id), int'({bgv, bav}), e.bank);
                chk($sformatf("dut%0d_ref_cycle", id), cyc[id], e.cyc);
                chk($sformatf("dut%0d_ref_A", id), int'(a), 32'h04001);
                chk($sformatf("dut%0d_ref_act_n", id), int'(act), 1);
            end
        end else begin
            chk($sformatf("dut%0d_idle_pins", id), int'({a, bgv, bav, act}), 1);
        end
        if (done) begin
            sweeps[id]++;
            chk($sformatf("dut%0d_grant_to_done", id), cyc[id] - grant_cyc[id], NB * gap + TRFC);
            chk($sformatf("dut%0d_refs_left_at_done", id), qs, 0);
            if (id == 1) begin
                chk("t5_pending_at_done", int'(pend), 1);
                after_done = 1'b1;
            end
            in_sweep[id] = 1'b0;
        end else if (id == 1 && after_done) begin
            chk("t5_pending_after_retire_tick", int'(pend), 1);
            chk("t5_no_overflow", int'(ovf), 0);
            after_done = 1'b0;
        end
        prev_req[id] = req;
        cyc[id]++;
    endtask

    always @(negedge ck_t) begin
        mon(0, GAP_A, rst_a, req_a, busy_a, cs_a[0], act_a, a_a, bg_a, ba_a, pend_a, ovf_a, done_a);
        mon(1, GAP_B, rst_b, req_b, busy_b, cs_b[0], act_b, a_b, bg_b, ba_b, pend_b, ovf_b, done_b);
    end

    typedef struct {
        bit rst;
        bit en;
        bit gnt;
        int cycles;
        int pend;
        bit ovf;
        bit req;
        bit busy;
        int sweeps;
    } vec_t;
    vec_t vecs[NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int found;
        // rst, en, gnt, cycles after release/phase start, pending, overflow, ref_req, ref_busy, sweeps
        vecs[0] = '{1, 0, 0,    0, 0, 0, 0, 0,  0};   // reset values
        vecs[1] = '{0, 1, 1,  150, 0, 0, 0, 0,  1};   // one sweep, pending back to 0
        vecs[2] = '{1, 1, 0,  400, 5, 0, 1, 0,  0};   // no grant for 5 intervals
        vecs[3] = '{0, 1, 1,   54, 4, 0, 1, 0,  1};   // grant: one sweep retires one
        vecs[4] = '{0, 1, 1,  656, 0, 0, 0, 0, 12};   // back-to-back sweeps drain to 0
        vecs[5] = '{1, 0, 0,  800, 8, 1, 0, 0,  0};   // saturate at 8, overflow sticky
        vecs[6] = '{0, 1, 1, 1195, 0, 1, 0, 0, 22};   // drain with overflow still set

        #12 rst_b = 1'b1;

        for (int p = 0; p < NVEC; p++) begin
            if (vecs[p].rst) begin
                rst_a = 1'b0;
                repeat (2) @(negedge ck_t);
                #1;
            end
            en_a  = vecs[p].en;
            gnt_a = vecs[p].gnt;
            rst_a = 1'b1;
            base  = sweeps[0];
            repeat (vecs[p].cycles) @(negedge ck_t);
            #1;
            chk($sformatf("v%0d_pending", p), int'(pend_a), vecs[p].pend);
            chk($sformatf("v%0d_overflow", p), int'(ovf_a), int'(vecs[p].ovf));
            chk($sformatf("v%0d_ref_req", p), int'(req_a), int'(vecs[p].req));
            chk($sformatf("v%0d_ref_busy", p), int'(busy_a), int'(vecs[p].busy));
            chk($sformatf("v%0d_sweeps", p), sweeps[0] - base, vecs[p].sweeps);
            chk($sformatf("v%0d_cs_n", p), int'(cs_a), 1);
            chk($sformatf("v%0d_ref_done", p), int'(done_a), 0);
        end

        // Reset asserted right after the 5th REF of a sweep
        rst_a = 1'b0;
        repeat (2) @(negedge ck_t);
        #1;
        en_a  = 1'b1;
        gnt_a = 1'b1;
        rst_a = 1'b1;
        base  = refs[0];
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge ck_t);
            #1;
            if (refs[0] - base == 5) found = 1;
        end
        chk("t6_fifth_ref_seen", found, 1);
        #1 rst_a = 1'b0;
        #1;
        chk("t6_cs_n_idle", int'(cs_a), 1);
        chk("t6_A_idle", int'(a_a), 0);
        chk("t6_bank_idle", int'({bg_a, ba_a}), 0);
        chk("t6_busy", int'(busy_a), 0);
        chk("t6_pending", int'(pend_a), 0);
        chk("t6_ref_req", int'(req_a), 0);
        repeat (3) @(negedge ck_t);
        #1 rst_a = 1'b1;
        repeat (60) @(negedge ck_t);
        #1;
        chk("t6_no_sixth_ref", refs[0] - base, 5);
        chk("t6_pending_after", int'(pend_a), 0);

        chk("t5_sweeps_observed", int'(sweeps[1] >= 30), 1);
        chk("t5_overflow_end", int'(ovf_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
